// File: rtl/pt_pkg.sv
// Shared types and default sizing for the page-table responder slice.
package pt_pkg;

  localparam int PT_VPN_W   = 20;
  localparam int PT_PFN_W   = 20;
  localparam int PT_IDX_W   = 6;
  localparam int PT_TAG_W   = PT_VPN_W - PT_IDX_W;
  localparam int PT_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    RESP,
    DROP
  } state_t;

  typedef struct packed {
    logic [PT_TAG_W-1:0] tag;
    logic [PT_PFN_W-1:0] pfn;
  } pte_t;

endpackage

// File: rtl/pt_entry_ram.sv
// Tag+PFN storage: one write port, one registered read port, read-before-write.
module pt_entry_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 34
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Both ports use non-blocking updates, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/page_table_responder.sv
// Page-table responder: direct-mapped tagged lookup with programmable latency.
// Optional miss reporting via the page_fault port when PT_FAULT_EN is defined.
module page_table_responder
  import pt_pkg::*;
#(
  parameter int VPN_W   = PT_VPN_W,
  parameter int PFN_W   = PT_PFN_W,
  parameter int IDX_W   = PT_IDX_W,
  parameter int LATENCY = PT_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             page_table_access,
  input  logic [VPN_W-1:0] virtual_page_number,
  output logic [PFN_W-1:0] page_table_frame,
  output logic             page_table_ready,
  input  logic             pt_wr_en,
  input  logic [VPN_W-1:0] pt_wr_vpn,
  input  logic [PFN_W-1:0] pt_wr_frame,
  input  logic             pt_wr_valid,
  output logic             busy
`ifdef PT_FAULT_EN
  ,
  output logic             page_fault
`endif
);

  localparam int DEPTH = 2**IDX_W;
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int ENT_W = TAG_W + PFN_W;
  localparam logic [3:0] WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t             state_q, state_d;
  logic [VPN_W-1:0]   req_vpn_q;
  logic [3:0]         wait_cnt_q;
  logic [DEPTH-1:0]   valid_q;
  logic               valid_rd_q;
  logic [PFN_W-1:0]   frame_q;
  logic [ENT_W-1:0]   ram_rdata;
  logic               hit;
`ifdef PT_FAULT_EN
  logic               miss_q;
`endif

  pt_entry_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (ENT_W)
  ) u_entry_ram (
    .clk       (clk),
    .wr_en_i   (pt_wr_en),
    .wr_addr_i (pt_wr_vpn[IDX_W-1:0]),
    .wr_data_i ({pt_wr_vpn[VPN_W-1:IDX_W], pt_wr_frame}),
    .rd_en_i   (state_q == READ),
    .rd_addr_i (req_vpn_q[IDX_W-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign hit = valid_rd_q && (ram_rdata[ENT_W-1:PFN_W] == req_vpn_q[VPN_W-1:IDX_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping the request before the response abandons the lookup silently.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (page_table_access) state_d = READ;
      READ:    if (!page_table_access) state_d = IDLE;
               else if (LATENCY == 0) state_d = CHECK;
               else state_d = WAIT;
      WAIT:    if (!page_table_access) state_d = IDLE;
               else if (wait_cnt_q == WAIT_LAST) state_d = CHECK;
      CHECK:   if (!page_table_access) state_d = IDLE;
               else state_d = RESP;
      RESP:    state_d = DROP;
      DROP:    if (!page_table_access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != IDLE);
    page_table_ready = (state_q == RESP);
`ifdef PT_FAULT_EN
    page_fault       = (state_q == RESP) && miss_q;
`endif
  end

  // Valid bits live in flops so reset clears every entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (pt_wr_en) begin
      valid_q[pt_wr_vpn[IDX_W-1:0]] <= pt_wr_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_vpn_q  <= '0;
      wait_cnt_q <= '0;
      valid_rd_q <= 1'b0;
      frame_q    <= '0;
`ifdef PT_FAULT_EN
      miss_q     <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && page_table_access) begin
        req_vpn_q <= virtual_page_number;
      end
      if (state_q == READ) begin
        valid_rd_q <= valid_q[req_vpn_q[IDX_W-1:0]];
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
      if (state_d == RESP) begin
        frame_q <= hit ? ram_rdata[PFN_W-1:0] : '0;
`ifdef PT_FAULT_EN
        miss_q  <= !hit;
`endif
      end
    end
  end

  assign page_table_frame = frame_q;

endmodule

// File: tb/tb_page_table_responder.sv
// Scoreboard bench for page_table_responder; expected lookups come from a table model.
module tb_page_table_responder;
  import pt_pkg::*;

  localparam int LAT = 2;
  localparam int VW  = 20;
  localparam int PW  = 20;
  localparam int IW  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          page_table_access;
  logic [VW-1:0] virtual_page_number;
  logic [PW-1:0] page_table_frame;
  logic          page_table_ready;
  logic          pt_wr_en;
  logic [VW-1:0] pt_wr_vpn;
  logic [PW-1:0] pt_wr_frame;
  logic          pt_wr_valid;
  logic          busy;
`ifdef PT_FAULT_EN
  logic          page_fault;
`endif

  typedef struct {
    logic [PW-1:0] frame;
    logic          fault;
  } exp_t;

  exp_t expQ[$];
  pte_t mEntry [2**IW];
  logic mValid [2**IW];
  int   testsRun = 0;
  int   testsFailed = 0;

  page_table_responder #(
    .VPN_W   (VW),
    .PFN_W   (PW),
    .IDX_W   (IW),
    .LATENCY (LAT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .page_table_access   (page_table_access),
    .virtual_page_number (virtual_page_number),
    .page_table_frame    (page_table_frame),
    .page_table_ready    (page_table_ready),
    .pt_wr_en            (pt_wr_en),
    .pt_wr_vpn           (pt_wr_vpn),
    .pt_wr_frame         (pt_wr_frame),
    .pt_wr_valid         (pt_wr_valid),
    .busy                (busy)
`ifdef PT_FAULT_EN
    ,
    .page_fault          (page_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelWrite(input logic [VW-1:0] vpn, input logic [PW-1:0] pfn, input logic valid);
    int idx;
    idx = int'(vpn[IW-1:0]);
    mValid[idx] = valid;
    mEntry[idx].tag = vpn[VW-1:IW];
    mEntry[idx].pfn = pfn;
  endtask

  function automatic exp_t modelLookup(input logic [VW-1:0] vpn);
    exp_t e;
    int   idx;
    logic hitM;
    idx     = int'(vpn[IW-1:0]);
    hitM    = mValid[idx] && (mEntry[idx].tag == vpn[VW-1:IW]);
    e.frame = hitM ? mEntry[idx].pfn : '0;
    e.fault = !hitM;
    return e;
  endfunction

  task automatic programEntry(input logic [VW-1:0] vpn, input logic [PW-1:0] pfn, input logic valid);
    @(negedge clk);
    pt_wr_en    = 1'b1;
    pt_wr_vpn   = vpn;
    pt_wr_frame = pfn;
    pt_wr_valid = valid;
    modelWrite(vpn, pfn, valid);
    @(negedge clk);
    pt_wr_en = 1'b0;
  endtask

  // One request; optionally a table write landing on the READ edge, then access held holdCycles after ready.
  task automatic applyStimulus(input string tag, input logic [VW-1:0] vpn, input bit doWrite,
                               input logic [VW-1:0] wVpn, input logic [PW-1:0] wPfn, input int holdCycles);
    exp_t e;
    int   cycles;
    int   extra;
    @(negedge clk);
    expQ.push_back(modelLookup(vpn));
    page_table_access   = 1'b1;
    virtual_page_number = vpn;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        if (doWrite) begin
          pt_wr_en    = 1'b1;
          pt_wr_vpn   = wVpn;
          pt_wr_frame = wPfn;
          pt_wr_valid = 1'b1;
          modelWrite(wVpn, wPfn, 1'b1);
        end
      end else if (cycles == 2) begin
        pt_wr_en = 1'b0;
      end
    end while (!page_table_ready && cycles < 50);
    pt_wr_en = 1'b0;
    e = expQ.pop_front();
    if (!page_table_ready) begin
      checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_latency"}, 32'(cycles), 32'(LAT + 3));
      checkOutput({tag, "_frame"}, 32'(page_table_frame), 32'(e.frame));
`ifdef PT_FAULT_EN
      checkOutput({tag, "_fault"}, 32'(page_fault), 32'(e.fault));
`endif
    end
    extra = 0;
    for (int i = 0; i < ((holdCycles > 1) ? holdCycles : 1); i++) begin
      @(negedge clk);
      if (page_table_ready) extra++;
    end
    checkOutput({tag, "_extra_ready"}, 32'(extra), 32'd0);
    checkOutput({tag, "_frame_hold"}, 32'(page_table_frame), 32'(e.frame));
    page_table_access = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    for (int i = 0; i < 2**IW; i++) mValid[i] = 1'b0;
    reset               = 1'b1;
    page_table_access   = 1'b0;
    virtual_page_number = '0;
    pt_wr_en            = 1'b0;
    pt_wr_vpn           = '0;
    pt_wr_frame         = '0;
    pt_wr_valid         = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(page_table_ready), 32'd0);
    checkOutput("rst_frame", 32'(page_table_frame), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef PT_FAULT_EN
    checkOutput("rst_fault", 32'(page_fault), 32'd0);
`endif
    reset = 1'b0;

    programEntry(20'h00041, 20'h12345, 1'b1);
    applyStimulus("t1_hit", 20'h00041, 1'b0, '0, '0, 1);

    applyStimulus("t2_miss", 20'h00099, 1'b0, '0, '0, 1);

    programEntry(20'h00081, 20'h54321, 1'b1);
    applyStimulus("t3_alias_old", 20'h00041, 1'b0, '0, '0, 1);
    applyStimulus("t3_alias_new", 20'h00081, 1'b0, '0, '0, 1);

    programEntry(20'h00041, 20'h12345, 1'b1);
    applyStimulus("t4_rbw", 20'h00041, 1'b1, 20'h00041, 20'h0ABCD, 1);
    applyStimulus("t4_retry", 20'h00041, 1'b0, '0, '0, 1);

    applyStimulus("t5_hold", 20'h00041, 1'b0, '0, '0, 10);
    applyStimulus("t5_next", 20'h00041, 1'b0, '0, '0, 1);

    programEntry(20'h00041, 20'h0ABCD, 1'b0);
    applyStimulus("inval", 20'h00041, 1'b0, '0, '0, 1);
    programEntry(20'h00041, 20'h12345, 1'b1);

    // Request withdrawn mid-lookup must never produce a response.
    @(negedge clk);
    page_table_access   = 1'b1;
    virtual_page_number = 20'h00041;
    repeat (2) @(negedge clk);
    page_table_access = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (page_table_ready) seen++;
    end
    checkOutput("drop_no_ready", 32'(seen), 32'd0);
    checkOutput("drop_idle", 32'(busy), 32'd0);

    // Reset landing in WAIT: no response and all entries invalidated.
    @(negedge clk);
    page_table_access   = 1'b1;
    virtual_page_number = 20'h00041;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_ready", 32'(page_table_ready), 32'd0);
    page_table_access = 1'b0;
    for (int i = 0; i < 2**IW; i++) mValid[i] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (page_table_ready) seen++;
    end
    checkOutput("t6_no_ready", 32'(seen), 32'd0);
    applyStimulus("t6_miss", 20'h00041, 1'b0, '0, '0, 1);
    applyStimulus("t6_alias_gone", 20'h00081, 1'b0, '0, '0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
